// File: rtl/bcd_pack_unit.sv
// Two-digit BCD <-> 8-bit binary conversion unit between the calculator's
// digit entry/display logic and its ALU. Both paths are registered, latency 1.
module bcd_pack_unit (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       join_vld_i,
  input  logic [3:0] join_tens_i,
  input  logic [3:0] join_ones_i,
  output logic       join_vld_o,
  output logic [7:0] join_val_o,
  output logic       join_err_o,
  input  logic       split_vld_i,
  input  logic [7:0] split_val_i,
  output logic       split_vld_o,
  output logic [1:0] split_hund_o,
  output logic [3:0] split_tens_o,
  output logic [3:0] split_ones_o,
  output logic       split_ovf_o
);

  logic [7:0] join_sum;
  logic       join_bad;

  logic [1:0] hund_c;
  logic [6:0] rem_h;
  logic [3:0] tens_c;
  logic [6:0] tens_x10;
  logic [3:0] ones_c;
  logic       ovf_c;

  // tens*10 as (tens<<3)+(tens<<1); the largest illegal pair 15,15 still fits
  always_comb begin
    join_sum = ({4'd0, join_tens_i} << 3) + ({4'd0, join_tens_i} << 1)
             + {4'd0, join_ones_i};
    join_bad = (join_tens_i > 4'd9) || (join_ones_i > 4'd9);
  end

  always_comb begin
    hund_c = 2'd0;
    rem_h  = split_val_i[6:0];
    if (split_val_i >= 8'd200) begin
      hund_c = 2'd2;
      rem_h  = 7'(split_val_i - 8'd200);
    end else if (split_val_i >= 8'd100) begin
      hund_c = 2'd1;
      rem_h  = 7'(split_val_i - 8'd100);
    end
    ovf_c = (split_val_i > 8'd99);

    // remainder is below 100, so the tens digit is the highest decade threshold reached
    tens_c = 4'd0;
    for (int t = 1; t < 10; t++) begin
      if (rem_h >= 7'(t * 10))
        tens_c = 4'(t);
    end
    tens_x10 = ({3'd0, tens_c} << 3) + ({3'd0, tens_c} << 1);
    ones_c   = 4'(rem_h - tens_x10);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      join_vld_o <= 1'b0;
      join_val_o <= 8'd0;
      join_err_o <= 1'b0;
    end else begin
      join_vld_o <= join_vld_i;
      if (join_vld_i) begin
        join_val_o <= join_sum;
        join_err_o <= join_bad;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      split_vld_o  <= 1'b0;
      split_hund_o <= 2'd0;
      split_tens_o <= 4'd0;
      split_ones_o <= 4'd0;
      split_ovf_o  <= 1'b0;
    end else begin
      split_vld_o <= split_vld_i;
      if (split_vld_i) begin
        split_hund_o <= hund_c;
        split_tens_o <= tens_c;
        split_ones_o <= ones_c;
        split_ovf_o  <= ovf_c;
      end
    end
  end

endmodule

// File: tb/tb_bcd_pack_unit.sv
// Scoreboard bench for bcd_pack_unit: stimulus pushes expected results from an
// arithmetic reference model, a negedge monitor pops and compares.
module tb_bcd_pack_unit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       join_vld_i;
  logic [3:0] join_tens_i;
  logic [3:0] join_ones_i;
  logic       join_vld_o;
  logic [7:0] join_val_o;
  logic       join_err_o;
  logic       split_vld_i;
  logic [7:0] split_val_i;
  logic       split_vld_o;
  logic [1:0] split_hund_o;
  logic [3:0] split_tens_o;
  logic [3:0] split_ones_o;
  logic       split_ovf_o;

  typedef struct {
    int         due;
    logic [7:0] val;
    logic       err;
  } join_exp_t;

  typedef struct {
    int         due;
    logic [1:0] hund;
    logic [3:0] tens;
    logic [3:0] ones;
    logic       ovf;
  } split_exp_t;

  join_exp_t  jq[$];
  split_exp_t sq[$];
  int         rst_q[$];

  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;

  bcd_pack_unit dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .join_vld_i   (join_vld_i),
    .join_tens_i  (join_tens_i),
    .join_ones_i  (join_ones_i),
    .join_vld_o   (join_vld_o),
    .join_val_o   (join_val_o),
    .join_err_o   (join_err_o),
    .split_vld_i  (split_vld_i),
    .split_val_i  (split_val_i),
    .split_vld_o  (split_vld_o),
    .split_hund_o (split_hund_o),
    .split_tens_o (split_tens_o),
    .split_ones_o (split_ones_o),
    .split_ovf_o  (split_ovf_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s at cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  // Drives one cycle of inputs and records what the reference model expects after the next edge
  task automatic applyStimulus(input bit rst, input bit jv, input int jt, input int jo,
                               input bit sv, input int sval);
    join_exp_t  je;
    split_exp_t se;
    rst_n       = !rst;
    join_vld_i  = jv;
    join_tens_i = 4'(jt);
    join_ones_i = 4'(jo);
    split_vld_i = sv;
    split_val_i = 8'(sval);
    if (rst) begin
      rst_q.push_back(cyc + 1);
    end else begin
      if (jv) begin
        je.due = cyc + 1;
        je.val = 8'(jt * 10 + jo);
        je.err = (jt > 9) || (jo > 9);
        jq.push_back(je);
      end
      if (sv) begin
        se.due  = cyc + 1;
        se.hund = 2'(sval / 100);
        se.tens = 4'((sval % 100) / 10);
        se.ones = 4'(sval % 10);
        se.ovf  = (sval > 99);
        sq.push_back(se);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      applyStimulus(1'b0, 1'b0, 0, 0, 1'b0, 0);
  endtask

  // Monitor: pops an expected result when its cycle comes due, otherwise expects held data
  initial begin : monitor
    logic [7:0] h_jval;
    logic       h_jerr;
    logic [1:0] h_hund;
    logic [3:0] h_tens;
    logic [3:0] h_ones;
    logic       h_ovf;
    logic       e_jv;
    logic       e_sv;
    join_exp_t  je;
    split_exp_t se;
    h_jval = '0; h_jerr = 1'b0;
    h_hund = '0; h_tens = '0; h_ones = '0; h_ovf = 1'b0;
    forever begin
      @(negedge clk);
      if (cyc > 0) begin
        e_jv = 1'b0;
        e_sv = 1'b0;
        if (rst_q.size() > 0 && rst_q[0] == cyc) begin
          void'(rst_q.pop_front());
          h_jval = '0; h_jerr = 1'b0;
          h_hund = '0; h_tens = '0; h_ones = '0; h_ovf = 1'b0;
        end
        if (jq.size() > 0 && jq[0].due == cyc) begin
          je = jq.pop_front();
          h_jval = je.val;
          h_jerr = je.err;
          e_jv = 1'b1;
        end
        if (sq.size() > 0 && sq[0].due == cyc) begin
          se = sq.pop_front();
          h_hund = se.hund;
          h_tens = se.tens;
          h_ones = se.ones;
          h_ovf  = se.ovf;
          e_sv = 1'b1;
        end
        checkOutput("join {vld,err,val}",
                    32'({join_vld_o, join_err_o, join_val_o}),
                    32'({e_jv, h_jerr, h_jval}));
        checkOutput("split {vld,ovf,hund,tens,ones}",
                    32'({split_vld_o, split_ovf_o, split_hund_o, split_tens_o, split_ones_o}),
                    32'({e_sv, h_ovf, h_hund, h_tens, h_ones}));
      end
    end
  end

  initial begin : stimulus
    rst_n = 1'b0;
    join_vld_i = 1'b0; join_tens_i = '0; join_ones_i = '0;
    split_vld_i = 1'b0; split_val_i = '0;

    applyStimulus(1'b1, 1'b0, 0, 0, 1'b0, 0);
    applyStimulus(1'b1, 1'b0, 0, 0, 1'b0, 0);
    idle(1);

    // back-to-back joins, then directed split values
    applyStimulus(1'b0, 1'b1, 1, 2, 1'b0, 0);
    applyStimulus(1'b0, 1'b1, 2, 3, 1'b0, 0);
    idle(1);
    applyStimulus(1'b0, 1'b0, 0, 0, 1'b1, 35);
    applyStimulus(1'b0, 1'b0, 0, 0, 1'b1, 245);
    applyStimulus(1'b0, 1'b0, 0, 0, 1'b1, 0);
    applyStimulus(1'b0, 1'b0, 0, 0, 1'b1, 99);
    applyStimulus(1'b0, 1'b0, 0, 0, 1'b1, 100);
    applyStimulus(1'b0, 1'b1, 10, 0, 1'b0, 0);
    applyStimulus(1'b0, 1'b1, 15, 15, 1'b0, 0);
    applyStimulus(1'b0, 1'b1, 9, 9, 1'b0, 0);

    // simultaneous paths, then hold with vld low
    applyStimulus(1'b0, 1'b1, 6, 7, 1'b1, 67);
    idle(3);

    // reset in the request cycle, and reset right after a request
    applyStimulus(1'b1, 1'b1, 4, 5, 1'b1, 200);
    idle(1);
    applyStimulus(1'b0, 1'b1, 8, 1, 1'b1, 255);
    applyStimulus(1'b1, 1'b0, 0, 0, 1'b0, 0);
    idle(2);

    for (int i = 0; i < 80; i++)
      applyStimulus(1'b0, 1'($urandom_range(1)), int'($urandom_range(15)),
                    int'($urandom_range(15)), 1'($urandom_range(1)),
                    int'($urandom_range(255)));

    // every split value, with random joins alongside
    for (int v = 0; v < 256; v++)
      applyStimulus(1'b0, 1'($urandom_range(1)), int'($urandom_range(9)),
                    int'($urandom_range(9)), 1'b1, v);
    idle(3);

    checkOutput("scoreboard drained", 32'(jq.size() + sq.size() + rst_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
